// File: rtl/din_debounce.sv
// din_debounce
//   Input conditioning stage placed in front of the positive-edge detector FSMs.
//   It synchronises an asynchronous raw input into the clk domain and only
//   accepts a new level after DEBOUNCE_CYCLES consecutive equal synced samples.
//   Every qualification that is aborted early is counted in a saturating
//   glitch counter.
//
// Ports
//   clk        in   1         rising-edge clock
//   rst        in   1         synchronous, active-high reset
//   din_raw    in   1         asynchronous raw input (button / line)
//   dout       out  1         debounced level (registered), feeds edge detector din
//   busy       out  1         1 while a level change is being qualified (registered)
//   glitch_cnt out  GLITCH_W  rejected transitions, saturates at all-ones (registered)

module din_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din_raw,
  output logic                dout,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GLITCH_W-1:0]    glitch_cnt_q, glitch_cnt_d;
  logic                   dout_q, dout_d;
  logic                   busy_q, busy_d;
  logic                   s;
  logic                   cnt_done;

  // Only the last synchroniser stage is allowed to influence the filter.
  assign s        = sync_q[SYNC_STAGES-1];
  assign cnt_done = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Synchroniser shift, state transitions, counters and output decode.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], din_raw};
    state_d      = state_q;
    cnt_d        = cnt_q;
    glitch_cnt_d = glitch_cnt_q;
    dout_d       = 1'b0;
    busy_d       = 1'b0;

    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          // Level fell back before qualification finished: reject it.
          state_d = STABLE_LO;
          cnt_d   = '0;
          if (glitch_cnt_q != {GLITCH_W{1'b1}}) begin
            glitch_cnt_d = glitch_cnt_q + GLITCH_W'(1);
          end else begin
            glitch_cnt_d = glitch_cnt_q;
          end
        end else if (cnt_done) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          // Level rose back before qualification finished: reject it.
          state_d = STABLE_HI;
          cnt_d   = '0;
          if (glitch_cnt_q != {GLITCH_W{1'b1}}) begin
            glitch_cnt_d = glitch_cnt_q + GLITCH_W'(1);
          end else begin
            glitch_cnt_d = glitch_cnt_q;
          end
        end else if (cnt_done) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // Unreachable encodings fall back to the safe low state.
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register together with it.
    if ((state_d == STABLE_HI) || (state_d == WAIT_LO)) begin
      dout_d = 1'b1;
    end else begin
      dout_d = 1'b0;
    end
    if ((state_d == WAIT_HI) || (state_d == WAIT_LO)) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // State, counter, synchroniser and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      state_q      <= STABLE_LO;
      cnt_q        <= '0;
      glitch_cnt_q <= '0;
      dout_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      glitch_cnt_q <= glitch_cnt_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign busy       = busy_q;
  assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_din_debounce.sv
// tb_din_debounce
//   Self-checking bench for din_debounce with default parameters.
//   A run-length reference model predicts dout/busy/glitch_cnt for each edge;
//   predictions are queued when the stimulus is driven and compared after the
//   edge. Directed latency, glitch and rising-level counts are checked as well.

module tb_din_debounce;

  localparam int SS = 2;
  localparam int DC = 4;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din_raw = 1'b0;
  logic          dout;
  logic          busy;
  logic [GW-1:0] glitch_cnt;

  din_debounce #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .GLITCH_W       (GW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_raw   (din_raw),
    .dout      (dout),
    .busy      (busy),
    .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          dout;
    logic          busy;
    logic [GW-1:0] glitch;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [SS-1:0] m_sync   = '0;
  int            m_run    = 0;
  logic          m_dout   = 1'b0;
  int            m_glitch = 0;

  logic prev_dout = 1'b0;
  int   rises     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict the post-edge outputs, compare.
  task automatic step(input logic raw, input logic r);
    exp_t  e;
    logic  s;
    @(negedge clk);
    din_raw = raw;
    rst     = r;
    if (r) begin
      m_sync   = '0;
      m_run    = 0;
      m_dout   = 1'b0;
      m_glitch = 0;
    end else begin
      s      = m_sync[SS-1];
      m_sync = {m_sync[SS-2:0], raw};
      if (s != m_dout) begin
        m_run++;
        if (m_run == DC) begin
          m_dout = s;
          m_run  = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
    e.dout   = m_dout;
    e.busy   = (m_run != 0);
    e.glitch = GW'(m_glitch);
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("dout", {31'd0, dout}, {31'd0, e.dout});
    check("busy", {31'd0, busy}, {31'd0, e.busy});
    check("glitch_cnt", {24'd0, glitch_cnt}, {24'd0, e.glitch});
    if (dout === 1'b1 && prev_dout === 1'b0) rises++;
    prev_dout = dout;
  endtask

  // Hold raw at lvl and count edges (first driven edge = 1) until dout follows.
  task automatic wait_level(input logic lvl, input int exp_edges, input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(lvl, 1'b0);
      n++;
      if (dout === lvl) break;
    end
    check(tag, n, exp_edges);
  endtask

  initial begin
    // 1. Reset for two cycles with din_raw low
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("rst_dout", {31'd0, dout}, 32'd0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // 2. Rising level: busy over edges 3..5, dout on the 6th edge
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("t2_busy_e3", {31'd0, busy}, 32'd1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("t2_dout_e5", {31'd0, dout}, 32'd0);
    step(1'b1, 1'b0);
    check("t2_dout_e6", {31'd0, dout}, 32'd1);
    check("t2_busy_e6", {31'd0, busy}, 32'd0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Return to low so the next test starts in STABLE_LO
    wait_level(1'b0, 6, "fall_lat");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

    // 3. Three-cycle high pulse is rejected
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    check("t3_glitch", {24'd0, glitch_cnt}, 32'd1);
    check("t3_dout", {31'd0, dout}, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd0);

    wait_level(1'b1, 6, "rise2_lat");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // 4. Low 2, high 1, then low held
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    wait_level(1'b0, 6, "t4_fall_lat");
    check("t4_glitch", {24'd0, glitch_cnt}, 32'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    // 5. 300 single-cycle glitches spaced 8 cycles apart
    for (int g = 0; g < 300; g++) begin
      step(1'b1, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    end
    check("t5_glitch_sat", {24'd0, glitch_cnt}, 32'd255);
    check("t5_dout", {31'd0, dout}, 32'd0);

    // 6. Reset in WAIT_HI with cnt=2, then full qualification again
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    check("t6_busy_pre", {31'd0, busy}, 32'd1);
    step(1'b1, 1'b1);
    check("t6_rst_dout", {31'd0, dout}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_glitch", {24'd0, glitch_cnt}, 32'd0);
    wait_level(1'b1, 6, "t6_lat");
    step(1'b1, 1'b0);

    // One rising dout edge per accepted rising level
    check("rise_count", rises, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
